// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
//   - access size encodings carried on req_size
//   - responder FSM state encoding
//   - number of byte lanes in a storage word
package dmem_pkg;

    localparam int LANES = 4;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the data-memory responder.
// Ports:
//   i_addr_lo    low two bits of the byte address
//   i_size       access size (SIZE_B / SIZE_H / SIZE_W, 11 illegal)
//   i_unsigned   load extension select (1 = zero, 0 = sign)
//   i_wdata      right-aligned store data
//   i_rword      full storage word being loaded
//   o_be         per-lane store enables
//   o_wdata      store data placed on its lanes
//   o_rdata      extracted and extended load data
//   o_misaligned illegal size or address not aligned to the size
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]       i_addr_lo,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    input  logic [31:0]      i_wdata,
    input  logic [31:0]      i_rword,
    output logic [LANES-1:0] o_be,
    output logic [31:0]      o_wdata,
    output logic [31:0]      o_rdata,
    output logic             o_misaligned
);

    // Addressed byte/halfword moved down to lane 0; for an aligned halfword
    // addr[0] is 0, so the same shift serves both sizes.
    logic [31:0] w_rsh;
    assign w_rsh = i_rword >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be         = '0;
        o_wdata      = '0;
        o_rdata      = '0;
        o_misaligned = 1'b0;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                // Replicating the byte puts it on every lane; o_be picks one.
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{~i_unsigned & w_rsh[7]}}, w_rsh[7:0]};
            end
            SIZE_H: begin
                o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata      = {2{i_wdata[15:0]}};
                o_rdata      = {{16{~i_unsigned & w_rsh[15]}}, w_rsh[15:0]};
                o_misaligned = i_addr_lo[0];
            end
            SIZE_W: begin
                o_be         = '1;
                o_wdata      = i_wdata;
                o_rdata      = i_rword;
                o_misaligned = |i_addr_lo;
            end
            default: o_misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: memory side of the MEM-stage load/store interface.
// One request at a time over valid/ready, WAIT_CYCLES wait states, then a
// registered response over a second valid/ready handshake.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid / req_ready        request handshake (ready only when idle)
//   req_write, req_addr,
//   req_wdata, req_size,
//   req_unsigned                 request fields, captured on acceptance
//   resp_valid / resp_ready      response handshake
//   resp_rdata, resp_error       registered response payload
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_e                r_state;
    state_e                w_next;
    logic [3:0]            r_cnt;

    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_size;
    logic                  r_unsigned;

    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_error;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic                  w_accept;
    logic                  w_commit;
    logic                  w_acc_write;
    logic [ADDR_WIDTH-1:0] w_acc_addr;
    logic [DATA_WIDTH-1:0] w_acc_wdata;
    logic [1:0]            w_acc_size;
    logic                  w_acc_unsigned;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_oor;
    logic                  w_misaligned;
    logic                  w_err;
    logic [LANES-1:0]      w_be;
    logic [31:0]           w_wdata_sh;
    logic [31:0]           w_rdata_ext;
    logic [31:0]           w_rword;

    assign w_accept = req_valid && req_ready;

    // The access commits on the edge that enters RESP. With no wait states
    // that is the acceptance edge itself, so the live request fields are used
    // instead of the captured copies.
    assign w_commit = (r_state == S_IDLE && w_accept && WAIT_CYCLES == 0) ||
                      (r_state == S_WAIT && r_cnt == 4'd0);

    assign w_acc_write    = (r_state == S_IDLE) ? req_write    : r_write;
    assign w_acc_addr     = (r_state == S_IDLE) ? req_addr     : r_addr;
    assign w_acc_wdata    = (r_state == S_IDLE) ? req_wdata    : r_wdata;
    assign w_acc_size     = (r_state == S_IDLE) ? req_size     : r_size;
    assign w_acc_unsigned = (r_state == S_IDLE) ? req_unsigned : r_unsigned;

    assign w_idx   = w_acc_addr[IDX_W+1:2];
    assign w_oor   = ({2'b00, w_acc_addr[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(DEPTH_WORDS));
    assign w_err   = w_oor || w_misaligned;
    assign w_rword = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_addr_lo   (w_acc_addr[1:0]),
        .i_size      (w_acc_size),
        .i_unsigned  (w_acc_unsigned),
        .i_wdata     (w_acc_wdata),
        .i_rword     (w_rword),
        .o_be        (w_be),
        .o_wdata     (w_wdata_sh),
        .o_rdata     (w_rdata_ext),
        .o_misaligned(w_misaligned)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP: if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FSM: outputs decoded from state only
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            S_IDLE:  req_ready  = 1'b1;
            S_RESP:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture: the requester may drop its fields after acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write    <= req_write;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
        end
    end

    // Response registers: written once per access and held through RESP.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_error <= 1'b0;
        end else if (w_commit) begin
            r_rdata <= (w_err || w_acc_write) ? '0 : w_rdata_ext;
            r_error <= w_err;
        end
    end

    // Storage: byte-enabled write, not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_commit && w_acc_write && !w_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_sh[8*i +: 8];
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_error = r_error;

endmodule
